// File: rtl/sim_run_ctrl_pkg.sv
// Shared definitions for the simulation run controller: state encodings,
// the FSM state type and the release-counter sizing helper.
package sim_run_ctrl_pkg;

  localparam logic [2:0] ST_HOLD    = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    S_HOLD    = ST_HOLD,
    S_RELEASE = ST_RELEASE,
    S_RUN     = ST_RUN,
    S_DONE    = ST_DONE,
    S_TIMEOUT = ST_TIMEOUT
  } run_state_e;

  // Bits needed to hold the last channel's release threshold.
  function automatic int rel_cnt_width(input int reset_cycles, input int num_dut,
                                       input int stagger);
    int span;
    span = reset_cycles + (num_dut - 1) * stagger;
    return (span < 1) ? 1 : $clog2(span + 1);
  endfunction

endpackage

// File: rtl/sim_run_sat_counter.sv
// Saturating up-counter with synchronous clear, count enable and freeze.
// Stops at all ones instead of wrapping.
module sim_run_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         frz,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && !frz && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: staggered per-DUT reset release, run-cycle counting, halt
// capture and done/timeout termination. Halt timestamps need SIM_RUN_CTRL_STAMP_EN.
import sim_run_ctrl_pkg::*;

module sim_run_ctrl #(
  parameter int NUM_DUT        = 1,
  parameter int RESET_CYCLES   = 1,
  parameter int STAGGER        = 0,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_DUT-1:0]       halt_i,
  output logic [NUM_DUT-1:0]       dut_reset_o,
  output logic                     running_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [NUM_DUT-1:0]       halted_o,
  output logic [NUM_DUT*CNT_W-1:0] halt_cycle_o
);

  localparam int REL_W = rel_cnt_width(RESET_CYCLES, NUM_DUT, STAGGER);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  // Handshake-free block: halt_i is a level qualified by the channel's own
  // released reset; outputs are registered and change only on clk edges.
  run_state_e           state_q;
  logic [REL_W-1:0]     rel_q;
  logic [REL_W:0]       rel_nxt;
  logic [NUM_DUT-1:0]   rel_hit;
  logic [NUM_DUT-1:0]   halted_n;
  logic                 all_halted_n;
  logic                 to_hit;
  logic                 in_seq;
  logic                 run_en;
  logic                 run_frz;

  always_comb begin
    in_seq       = (state_q == S_HOLD) || (state_q == S_RELEASE);
    rel_nxt      = {1'b0, rel_q} + (REL_W+1)'(1);
    rel_hit      = '0;
    for (int i = 0; i < NUM_DUT; i++) begin
      rel_hit[i] = in_seq && (rel_nxt >= (REL_W+1)'(RESET_CYCLES + i * STAGGER));
    end
    // Channels still held in reset cannot report a halt.
    halted_n     = halted_o | (halt_i & ~dut_reset_o);
    all_halted_n = &halted_n;
    to_hit       = (({1'b0, cycle_cnt_o} + (CNT_W+1)'(1)) == TO_LIM);
    run_en       = (state_q == S_RUN) && !all_halted_n;
    run_frz      = (state_q == S_DONE) || (state_q == S_TIMEOUT);
  end

  sim_run_sat_counter #(.W(REL_W)) u_rel_cnt (
    .clk (clk),
    .clr (reset),
    .en  (in_seq),
    .frz (1'b0),
    .q   (rel_q)
  );

  sim_run_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk (clk),
    .clr (reset),
    .en  (run_en),
    .frz (run_frz),
    .q   (cycle_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HOLD;
      dut_reset_o <= '1;
      halted_o    <= '0;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD, S_RELEASE: begin
          dut_reset_o <= dut_reset_o & ~rel_hit;
          halted_o    <= halted_n;
          if (rel_hit[NUM_DUT-1]) begin
            if (all_halted_n) begin
              state_q <= S_DONE;
              done_o  <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              running_o <= 1'b1;
            end
          end else if (rel_hit[0]) begin
            state_q <= S_RELEASE;
          end
        end
        S_RUN: begin
          halted_o <= halted_n;
          // A final halt on the timeout edge still counts as done.
          if (all_halted_n) begin
            state_q   <= S_DONE;
            done_o    <= 1'b1;
            running_o <= 1'b0;
          end else if (to_hit) begin
            state_q   <= S_TIMEOUT;
            timeout_o <= 1'b1;
            running_o <= 1'b0;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

`ifdef SIM_RUN_CTRL_STAMP_EN
  logic [NUM_DUT*CNT_W-1:0] stamp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q <= '0;
    end else if ((state_q == S_RELEASE) || (state_q == S_RUN)) begin
      for (int i = 0; i < NUM_DUT; i++) begin
        if (halted_n[i] && !halted_o[i]) begin
          stamp_q[i*CNT_W +: CNT_W] <= cycle_cnt_o;
        end
      end
    end
  end

  assign halt_cycle_o = stamp_q;
`else
  assign halt_cycle_o = '0;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: three instances with different parameter sets,
// directed stimulus, expected-value queue checked by a negedge monitor.
module tb_sim_run_ctrl;

  logic clk;

  logic        rst_a, rst_b, rst_c;
  logic [0:0]  halt_a;
  logic [1:0]  halt_b;
  logic [2:0]  halt_c;

  logic [0:0]  dr_a, hd_a;
  logic [1:0]  dr_b, hd_b;
  logic [2:0]  dr_c, hd_c;
  logic        run_a, run_b, run_c;
  logic        done_a, done_b, done_c;
  logic        to_a, to_b, to_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;
  logic [31:0] hc_a;
  logic [63:0] hc_b;
  logic [95:0] hc_c;

  sim_run_ctrl #(.NUM_DUT(1), .RESET_CYCLES(1), .STAGGER(0), .TIMEOUT_CYCLES(1000), .CNT_W(32)) u_dut_a (
    .clk(clk), .reset(rst_a), .halt_i(halt_a), .dut_reset_o(dr_a), .running_o(run_a),
    .done_o(done_a), .timeout_o(to_a), .cycle_cnt_o(cnt_a), .halted_o(hd_a), .halt_cycle_o(hc_a)
  );

  sim_run_ctrl #(.NUM_DUT(2), .RESET_CYCLES(1), .STAGGER(0), .TIMEOUT_CYCLES(20), .CNT_W(32)) u_dut_b (
    .clk(clk), .reset(rst_b), .halt_i(halt_b), .dut_reset_o(dr_b), .running_o(run_b),
    .done_o(done_b), .timeout_o(to_b), .cycle_cnt_o(cnt_b), .halted_o(hd_b), .halt_cycle_o(hc_b)
  );

  sim_run_ctrl #(.NUM_DUT(3), .RESET_CYCLES(4), .STAGGER(2), .TIMEOUT_CYCLES(1000), .CNT_W(32)) u_dut_c (
    .clk(clk), .reset(rst_c), .halt_i(halt_c), .dut_reset_o(dr_c), .running_o(run_c),
    .done_o(done_c), .timeout_o(to_c), .cycle_cnt_o(cnt_c), .halted_o(hd_c), .halt_cycle_o(hc_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  localparam int W = 64;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           exp_sel_q[$];
  string        exp_tag_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] mon_act;

  function automatic logic [W-1:0] st(input logic [2:0] r, input logic run, input logic done,
                                      input logic to, input logic [2:0] h, input logic [31:0] c);
    return {23'd0, r, run, done, to, h, c};
  endfunction

  function automatic logic [W-1:0] stamp2(input logic [31:0] h1, input logic [31:0] h0);
`ifdef SIM_RUN_CTRL_STAMP_EN
    return {h1, h0};
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [W-1:0] snap(input int sel);
    case (sel)
      0:       return st({2'b00, dr_a}, run_a, done_a, to_a, {2'b00, hd_a}, cnt_a);
      1:       return st({1'b0, dr_b}, run_b, done_b, to_b, {1'b0, hd_b}, cnt_b);
      2:       return st(dr_c, run_c, done_c, to_c, hd_c, cnt_c);
      3:       return hc_b;
      4:       return {32'd0, hc_a};
      default: return hc_c[63:0];
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_cyc_q[i] <= edge_n) begin
        mon_act = snap(exp_sel_q[i]);
        n_checks++;
        if (exp_cyc_q[i] < edge_n || mon_act !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (edge %0d)", exp_tag_q[i], mon_act, exp_q[i], edge_n);
        end
        exp_q.delete(i);
        exp_cyc_q.delete(i);
        exp_sel_q.delete(i);
        exp_tag_q.delete(i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int k, input int sel, input logic [W-1:0] v, input string tag);
    exp_q.push_back(v);
    exp_cyc_q.push_back(edge_n + k);
    exp_sel_q.push_back(sel);
    exp_tag_q.push_back(tag);
  endtask

  task automatic set_rst(input int which, input logic v);
    case (which)
      0:       rst_a = v;
      1:       rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  // Two reset edges, reset-state check, then reset released at a negedge.
  task automatic reset_seq(input int which);
    logic [2:0] ones;
    ones = (which == 0) ? 3'b001 : (which == 1) ? 3'b011 : 3'b111;
    set_rst(which, 1'b1);
    push(2, which, st(ones, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0), "reset_state");
    if (which == 1) push(2, 3, 64'd0, "b_stamp_reset");
    wait_neg(2);
    set_rst(which, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    halt_a = '0; halt_b = '0; halt_c = '0;
    wait_neg(1);

    // Defaults: single channel, done at run cycle 10.
    reset_seq(0);
    push(1,  0, st(3'b000, 1, 0, 0, 3'b000, 32'd0),  "a_run_entry");
    push(2,  0, st(3'b000, 1, 0, 0, 3'b000, 32'd1),  "a_count");
    push(11, 0, st(3'b000, 1, 0, 0, 3'b000, 32'd10), "a_cycle10");
    push(12, 0, st(3'b000, 0, 1, 0, 3'b001, 32'd10), "a_done");
    push(12, 4, {32'd0, stamp2(32'd0, 32'd10)} & 64'hffff_ffff, "a_stamp");
    push(15, 0, st(3'b000, 0, 1, 0, 3'b001, 32'd10), "a_done_hold");
    wait_neg(11);
    halt_a = 1'b1;
    wait_neg(2);
    halt_a = 1'b0;
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL a_direct_done: done_a=%b", done_a);
    end
    n_checks++;
    if (cnt_a !== 32'd10) begin
      n_fail++;
      $display("FAIL a_direct_cnt: cnt_a=%0d", cnt_a);
    end
    n_checks++;
    if (hd_a !== 1'b1) begin
      n_fail++;
      $display("FAIL a_direct_halted: hd_a=%b", hd_a);
    end
    wait_neg(3);

    // Timeout with no halts.
    reset_seq(1);
    push(1,  1, st(3'b000, 1, 0, 0, 3'b000, 32'd0),  "b_run_entry");
    push(20, 1, st(3'b000, 1, 0, 0, 3'b000, 32'd19), "b_pre_timeout");
    push(21, 1, st(3'b000, 0, 0, 1, 3'b000, 32'd20), "b_timeout");
    push(25, 1, st(3'b000, 0, 0, 1, 3'b000, 32'd20), "b_timeout_hold");
    wait_neg(26);
    n_checks++;
    if (to_b !== 1'b1) begin
      n_fail++;
      $display("FAIL b_direct_timeout: to_b=%b", to_b);
    end
    n_checks++;
    if (cnt_b !== 32'd20) begin
      n_fail++;
      $display("FAIL b_direct_cnt: cnt_b=%0d", cnt_b);
    end
    n_checks++;
    if (run_b !== 1'b0 || done_b !== 1'b0) begin
      n_fail++;
      $display("FAIL b_direct_flags: run_b=%b done_b=%b", run_b, done_b);
    end

    // Final halt on the timeout edge: done wins.
    reset_seq(1);
    push(7,  1, st(3'b000, 1, 0, 0, 3'b001, 32'd6),  "b_halt0");
    push(21, 1, st(3'b000, 0, 1, 0, 3'b011, 32'd19), "b_done_on_timeout_edge");
    push(21, 3, stamp2(32'd19, 32'd5), "b_stamp_race");
    wait_neg(6);
    halt_b = 2'b01;
    wait_neg(14);
    halt_b = 2'b11;
    wait_neg(1);
    halt_b = 2'b00;
    n_checks++;
    if (done_b !== 1'b1 || to_b !== 1'b0) begin
      n_fail++;
      $display("FAIL b_direct_race: done_b=%b to_b=%b", done_b, to_b);
    end
    wait_neg(4);

    // Halt timestamps at cycles 3 and 9.
    reset_seq(1);
    push(5,  3, stamp2(32'd0, 32'd3), "b_stamp_first");
    push(11, 1, st(3'b000, 0, 1, 0, 3'b011, 32'd9), "b_stamp_done");
    push(11, 3, stamp2(32'd9, 32'd3), "b_stamp_both");
    wait_neg(4);
    halt_b = 2'b01;
    wait_neg(6);
    halt_b = 2'b11;
    wait_neg(4);
    halt_b = 2'b00;

    // Staggered release, masked halt, mid-run reset.
    reset_seq(2);
    push(3,  2, st(3'b111, 0, 0, 0, 3'b000, 32'd0), "c_hold_e3");
    push(4,  2, st(3'b110, 0, 0, 0, 3'b000, 32'd0), "c_rel0_e4");
    push(5,  2, st(3'b110, 0, 0, 0, 3'b000, 32'd0), "c_rel_e5");
    push(6,  2, st(3'b100, 0, 0, 0, 3'b000, 32'd0), "c_rel1_e6");
    push(7,  2, st(3'b100, 0, 0, 0, 3'b001, 32'd0), "c_halt_masked_e7");
    push(8,  2, st(3'b000, 1, 0, 0, 3'b001, 32'd0), "c_run_e8");
    push(8,  5, 64'd0, "c_stamp_release");
    push(9,  2, st(3'b000, 1, 0, 0, 3'b001, 32'd1), "c_count");
    push(15, 2, st(3'b000, 1, 0, 0, 3'b001, 32'd7), "c_cycle7");
    push(16, 2, st(3'b111, 0, 0, 0, 3'b000, 32'd0), "c_midrun_reset");
    wait_neg(6);
    halt_c = 3'b101;
    wait_neg(1);
    halt_c = 3'b000;
    wait_neg(8);
    rst_c = 1'b1;
    wait_neg(1);
    rst_c = 1'b0;
    n_checks++;
    if (dr_c !== 3'b111) begin
      n_fail++;
      $display("FAIL c_direct_reset: dr_c=%b", dr_c);
    end
    push(4, 2, st(3'b110, 0, 0, 0, 3'b000, 32'd0), "c_repeat_rel0");
    push(8, 2, st(3'b000, 1, 0, 0, 3'b000, 32'd0), "c_repeat_run");
    push(9, 2, st(3'b000, 1, 0, 0, 3'b000, 32'd1), "c_repeat_count");
    wait_neg(11);

    // ---------------- report ----------------
    wait_neg(2);
    #1;
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unchecked expected %h (edge %0d)", exp_tag_q[0], exp_q[0], exp_cyc_q[0]);
      exp_q.delete(0);
      exp_cyc_q.delete(0);
      exp_sel_q.delete(0);
      exp_tag_q.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Parametrised run controller for the multi-cycle CPU / ASIC simulation and bring-up environment.
- Drives per-DUT reset lines with a programmable hold time and staggered release.
- Counts run cycles and monitors per-DUT halt indications.
- Terminates with done or timeout status, so regression benches stop on a defined condition rather than a fixed delay.

Parameters:
- NUM_DUT, 1, number of DUT channels (each has its own reset output and halt input), range 1..8.
- RESET_CYCLES, 1, clock edges with reset low before channel 0 reset is released, minimum 1.
- STAGGER, 0, extra clock edges between releases of consecutive channels.
- TIMEOUT_CYCLES, 1000, run-cycle limit before timeout, minimum 1.
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  input  1  system clock
- reset  input  1  master reset; synchronous, active-high
- halt_i  input  NUM_DUT  per-channel halt/finished flag from DUT
- dut_reset_o  output  NUM_DUT  per-channel DUT reset; active-high, synchronous to clk
- running_o  output  1  high while in RUN
- done_o  output  1  sticky; all channels halted
- timeout_o  output  1  sticky; limit reached before all channels halted
- cycle_cnt_o  output  CNT_W  run-cycle count
- halted_o  output  NUM_DUT  sticky per-channel halt record
- halt_cycle_o  output  NUM_DUT*CNT_W  per-channel halt timestamp (see Optional Feature)

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. Everything updates on the rising edge of clk.
- Values while reset is high, and on the edge after reset is sampled high:
  - dut_reset_o = all ones
  - running_o, done_o, timeout_o = 0
  - cycle_cnt_o = 0, halted_o = 0, halt_cycle_o = 0
  - state = HOLD, release counter = 0
- State machine: HOLD -> RELEASE -> RUN -> {DONE | TIMEOUT}. DONE and TIMEOUT are terminal until reset.
- HOLD:
  - Release counter increments on each edge with reset low.
  - Channel i: dut_reset_o[i] goes low on the edge where the counter reaches RESET_CYCLES + i*STAGGER.
  - Example: RESET_CYCLES=1, STAGGER=0 -> all channels released on the first edge after reset falls.
- RELEASE: entered after channel 0 release. Stays until the last channel is released. Skipped (direct to RUN) when STAGGER=0 or NUM_DUT=1.
- RUN:
  - Entered on the same edge the last channel is released; running_o = 1 from that edge.
  - cycle_cnt_o increments once per edge in RUN and saturates at all ones (no wrap).
- Halt capture:
  - halt_i[i] is sampled only when dut_reset_o[i] = 0. Halts from channels still in reset are ignored.
  - halted_o[i] is set on the first sampled high and is sticky. A later deassertion of halt_i has no effect.
- Exit from RUN:
  - To DONE on the edge where halted_o (including bits set this edge) becomes all ones.
  - To TIMEOUT on the edge where cycle_cnt_o would reach TIMEOUT_CYCLES and not all channels are halted.
  - The exit edge sets done_o or timeout_o, clears running_o and freezes cycle_cnt_o.
- Simultaneous events: final halt and timeout on the same edge -> DONE wins; timeout_o stays 0.
- Channels halting during RELEASE are recorded. If every channel halts before RUN, DONE is entered on the RUN-entry edge.
- DONE/TIMEOUT: dut_reset_o stays released; all status outputs hold.
- Reset mid-operation: reset high in any state returns to the reset values on that edge, with all DUT resets reasserted.

Optional Feature:
- Macro: SIM_RUN_CTRL_STAMP_EN.
- Defined: on the edge halted_o[i] is set, halt_cycle_o[i*CNT_W +: CNT_W] captures the current cycle_cnt_o value (pre-increment). The value is held until reset. A halt during RELEASE stamps 0.
- Undefined: halt_cycle_o is tied to 0 and no stamp registers are built. The port list is identical in both builds.

Decomposition:
- Package sim_run_ctrl_pkg:
  - state encoding localparams: ST_HOLD, ST_RELEASE, ST_RUN, ST_DONE, ST_TIMEOUT (3-bit)
  - release-counter width function (clog2 of RESET_CYCLES + (NUM_DUT-1)*STAGGER + 1)
- One natural sub-module: sim_run_sat_counter, a saturating up-counter with synchronous clear, enable and freeze. Used for both the release counter and the run counter.

Test Plan:
- Defaults (NUM_DUT=1, RESET_CYCLES=1): reset high for 2 edges then low -> dut_reset_o=0 and running_o=1 on the first low edge. halt_i high at run cycle 10 -> done_o=1, cycle_cnt_o=10, timeout_o=0.
- NUM_DUT=3, RESET_CYCLES=4, STAGGER=2 -> channels release on edges 4, 6 and 8 after reset falls. running_o rises on edge 8.
- TIMEOUT_CYCLES=20, halt_i held 0 -> timeout_o=1 with cycle_cnt_o=20 frozen, running_o=0, done_o stays 0.
- NUM_DUT=2, TIMEOUT_CYCLES=20: halt_i[0] at cycle 5, halt_i[1] arriving on the timeout edge -> done_o=1, timeout_o=0, halted_o=2'b11.
- halt_i[2] pulsed while dut_reset_o[2]=1 -> ignored (halted_o[2]=0). Reset pulsed at run cycle 7 -> all dut_reset_o=1 and cycle_cnt_o=0 next edge, then the release sequence repeats.
- With SIM_RUN_CTRL_STAMP_EN, NUM_DUT=2: halts at cycles 3 and 9 -> halt_cycle_o fields = 3 and 9. Without the macro -> halt_cycle_o = 0.
